// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The nibble width is fixed by the single 4-bit adder slice.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca4_slice.sv
// Combinational 4-bit ripple-carry adder slice.
// The nibble-serial adder time-shares this one slice across all nibbles.
module nibble_serial_adder_rca4_slice
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);

   always_comb begin
      logic carry;
      carry = ci;
      s     = '0;
      for (int i = 0; i < NIBBLE_W; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      co = carry;
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder: one 4-bit nibble per clock through a single slice, valid/ready on both sides.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIB = WIDTH / NIBBLE_W;
   localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

   if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
   end

   state_t              state;
   logic [KW-1:0]       k;
   logic [WIDTH-1:0]    a_reg;
   logic [WIDTH-1:0]    b_reg;
   logic [WIDTH-1:0]    sum_r;
   logic                carry;
   logic                cout_r;
   logic [NIBBLE_W-1:0] a_nib;
   logic [NIBBLE_W-1:0] b_nib;
   logic [NIBBLE_W-1:0] s_nib;
   logic                s_co;
   logic                last;

   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIB; i++) begin
         if (k == KW'(i)) begin
            a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
            b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   assign last = (k == KW'(NIB - 1));

   nibble_serial_adder_rca4_slice u_rca4_slice (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry),
      .s  (s_nib),
      .co (s_co)
   );

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic ovf_r;
   logic msb_ci;
   // Carry into the slice MSB is recoverable from its sum bit and operand bits.
   assign msb_ci = s_nib[NIBBLE_W-1] ^ a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1];
   assign ovf    = ovf_r;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         k      <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         sum_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         ovf_r  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  carry <= cin;
                  k     <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NIB; i++) begin
                  if (k == KW'(i)) sum_r[i*NIBBLE_W +: NIBBLE_W] <= s_nib;
               end
               carry <= s_co;
               k     <= k + 1'b1;
               if (last) begin
                  cout_r <= s_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                  ovf_r  <= msb_ci ^ s_co;
`endif
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);
   assign sum       = sum_r;
   assign cout      = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a transaction-level reference model.
// Build with NIBBLE_SERIAL_ADDER_OVF_EN defined to also check ovf.
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a transaction takes NIB edges, then waits for out_ready.
   int               m_st = 0;   // 0 idle, 1 computing, 2 result offered
   int               m_cnt = 0;
   int               m_acc = 0;
   int               dut_acc = 0;
   logic [WIDTH:0]   m_pend = '0;
   logic             m_pend_ovf = 1'b0;
   logic [WIDTH-1:0] m_sum = '0;
   logic             m_cout = 1'b0;
   logic             m_ovf = 1'b0;

   always @(posedge clk) begin
      int sa;
      if (!rst && in_valid && in_ready) dut_acc++;
      if (rst) begin
         m_st = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      end else if (m_st == 0) begin
         if (in_valid) begin
            m_pend = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            sa = int'($signed(a)) + int'($signed(b)) + int'(cin);
            m_pend_ovf = (sa > (2**(WIDTH-1)) - 1) || (sa < -(2**(WIDTH-1)));
            m_cnt = NIB;
            m_st  = 1;
            m_acc++;
         end
      end else if (m_st == 1) begin
         m_cnt--;
         if (m_cnt == 0) begin
            {m_cout, m_sum} = m_pend;
            m_ovf = m_pend_ovf;
            m_st  = 2;
         end
      end else if (out_ready) begin
         m_st = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_in_ready", 32'(in_ready), 32'(m_st == 0));
         chk("cyc_out_valid", 32'(out_valid), 32'(m_st == 2));
         chk("cyc_busy", 32'(busy), 32'(m_st != 0));
         if (m_st != 1) begin
            chk("cyc_sum", 32'(sum), 32'(m_sum));
            chk("cyc_cout", 32'(cout), 32'(m_cout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
`endif
         end
      end
   end

   task automatic wait_out(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (out_valid) return;
      end
      total++;
      bad++;
      $display("FAIL wait_out: out_valid never rose, got 0 expected 1");
      n = -1;
   endtask

   task automatic chk_result(input string name, input logic [WIDTH-1:0] es,
                             input logic ec, input logic eo);
      chk({name, "_sum"}, 32'(sum), 32'(es));
      chk({name, "_cout"}, 32'(cout), 32'(ec));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      chk({name, "_ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("unexpected X in expected ovf");
`endif
   endtask

   task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
      int n;
      @(posedge clk); #1;
      a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = ~tc;
      wait_out(n);
      chk({name, "_latency"}, 32'(n), 32'(NIB));
      chk_result(name, es, ec, eo);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);

      run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

      // Backpressure: hold the result, ignore a stray in_valid pulse
      @(posedge clk); #1;
      a = 16'h1111; b = 16'h2222; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      wait_out(n);
      chk_result("bp", 16'h3334, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; end
         else in_valid = 1'b0;
         @(negedge clk);
         chk("bp_hold_sum", 32'(sum), 32'h3334);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);

      // Reset on the edge where the third nibble is being added
      @(posedge clk); #1;
      a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_sum", 32'(sum), 32'd0);
      run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

      // Back-to-back with in_valid held and out_ready tied high
      @(posedge clk); #1;
      a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      a = 16'h8000; b = 16'h8000;
      wait_out(n);
      chk("b2b1_latency", 32'(n), 32'(NIB));
      chk_result("b2b1", 16'h0002, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1 in_valid = 1'b0;
      wait_out(n);
      chk("b2b2_latency", 32'(n), 32'(NIB));
      chk_result("b2b2", 16'h0000, 1'b1, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_idle", 32'(in_ready), 32'd1);

      chk("accepts_dut", 32'(dut_acc), 32'd9);
      chk("accepts_model", 32'(m_acc), 32'd9);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
